// File: rtl/lite16_wb_pkg.sv
// -----------------------------------------------------------------------------
// lite16_wb_pkg
// Shared types and constants for the lite16 register writeback path.
//   REG_IDX_W  : width of a register index
//   DATA_W     : width of a register value
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one queued writeback {dst, data}
//   reg_onehot : index -> one-hot register mask
// -----------------------------------------------------------------------------
package lite16_wb_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  typedef struct packed {
    reg_idx_t dst;
    data_t    data;
  } wb_entry_t;

  function automatic reg_mask_t reg_onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/register_writeback_unit_if.sv
// -----------------------------------------------------------------------------
// register_writeback_unit_if
// Producer -> writeback unit result handshake.
//   in_valid : producer has a result this cycle
//   in_ready : unit can accept a result this cycle
//   in_wr    : result targets a register (0 = consume and discard)
//   in_dst   : destination register index
//   in_data  : result value
// Modports: master = producer, slave = writeback unit.
// -----------------------------------------------------------------------------
interface register_writeback_unit_if;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_wr;
  lite16_wb_pkg::reg_idx_t  in_dst;
  lite16_wb_pkg::data_t     in_data;

  modport master (output in_valid, in_wr, in_dst, in_data, input  in_ready);
  modport slave  (input  in_valid, in_wr, in_dst, in_data, output in_ready);

endinterface

// File: rtl/register_writeback_unit_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular queue of writeback entries with head/tail pointers and occupancy.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push_i      : write wdata_i at tail (ignored when full)
//   pop_i       : advance head (ignored when empty)
//   flush_i     : empty the queue at the edge; wins over push/pop
//   wdata_i     : entry to enqueue
//   head_o      : entry at head
//   count_o     : occupancy 0..DEPTH
//   slot_o      : all entries in age order, slot 0 = oldest (head)
//   slot_vld_o  : slot_o[k] holds a live entry
// -----------------------------------------------------------------------------
module wb_fifo
  import lite16_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  wb_entry_t              wdata_i,
  output wb_entry_t              head_o,
  output logic [CNT_W-1:0]       count_o,
  output wb_entry_t [DEPTH-1:0]  slot_o,
  output logic [DEPTH-1:0]       slot_vld_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push_i && (count_q != FULL) && !flush_i;
  assign do_pop  = pop_i  && (count_q != '0)   && !flush_i;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // increment wraps modulo DEPTH on its own.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q alone decides which slots are live,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // Age-ordered view for the scoreboard and forwarding logic.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_o[k]     = mem_q[head_q + PTR_W'(k)];
      slot_vld_o[k] = CNT_W'(k) < count_q;
    end
  end

endmodule

// File: rtl/register_writeback_unit.sv
// -----------------------------------------------------------------------------
// register_writeback_unit
// Queues producer results and drains one per cycle into the register file.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_if (slave)     : result handshake (in_valid/in_ready/in_wr/in_dst/in_data)
//   hold              : register-file write port busy this cycle, stall drain
//   flush             : discard all queued results at the edge
//   r, en             : register-file write data and one-hot write enable
//   busy              : per-register "pending write queued" mask
//   fwd_sel_a/b       : forwarding lookup indices
//   fwd_hit_a/b       : lookup matched a queued entry
//   fwd_data_a/b      : value of the youngest matching entry
// Configuration: define WB_FORWARD_EN to enable forwarding; otherwise the
// forwarding outputs are tied to zero.
// -----------------------------------------------------------------------------
module register_writeback_unit
  import lite16_wb_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                        clk,
  input  logic                        rst,
  register_writeback_unit_if.slave    in_if,
  input  logic                        hold,
  input  logic                        flush,
  output data_t                       r,
  output reg_mask_t                   en,
  output reg_mask_t                   busy,
  input  reg_idx_t                    fwd_sel_a,
  input  reg_idx_t                    fwd_sel_b,
  output logic                        fwd_hit_a,
  output logic                        fwd_hit_b,
  output data_t                       fwd_data_a,
  output data_t                       fwd_data_b
);

  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  wb_entry_t             head;
  logic [CNT_W-1:0]      count;
  wb_entry_t [DEPTH-1:0] slot;
  logic [DEPTH-1:0]      slot_vld;

  logic accept;
  logic push;
  logic drain;

  // Readiness looks only at the pre-edge count: a pop from a full queue
  // frees the slot for the next cycle, not this one.
  assign in_if.in_ready = !rst && !flush && (count != FULL);
  assign accept         = in_if.in_valid && in_if.in_ready;
  // Accepted results with in_wr = 0 are consumed without entering the queue.
  assign push           = accept && in_if.in_wr;

  // The register file captures r/en on the same edge the head pops.
  assign drain = !rst && !flush && !hold && (count != '0);
  assign en    = drain ? reg_onehot(head.dst) : '0;
  assign r     = drain ? head.data : '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (drain),
    .flush_i    (flush),
    .wdata_i    ('{dst: in_if.in_dst, data: in_if.in_data}),
    .head_o     (head),
    .count_o    (count),
    .slot_o     (slot),
    .slot_vld_o (slot_vld)
  );

  always_comb begin
    busy = '0;
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_vld[k]) busy |= reg_onehot(slot[k].dst);
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Slots run oldest to youngest, so the last match is the youngest entry.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_vld[k] && (slot[k].dst == fwd_sel_a)) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = slot[k].data;
        end
        if (slot_vld[k] && (slot[k].dst == fwd_sel_b)) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = slot[k].data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_sel_a, fwd_sel_b};
  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_register_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_register_writeback_unit
// Directed stimulus; accepted writes are queued as expected register-file
// writes and a negedge monitor compares every en/r pulse against that queue.
// -----------------------------------------------------------------------------
module tb_register_writeback_unit;
  import lite16_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic      clk   = 1'b0;
  logic      rst   = 1'b1;
  logic      hold  = 1'b0;
  logic      flush = 1'b0;
  reg_idx_t  fwd_sel_a = '0;
  reg_idx_t  fwd_sel_b = '0;
  data_t     r;
  reg_mask_t en;
  reg_mask_t busy;
  logic      fwd_hit_a, fwd_hit_b;
  data_t     fwd_data_a, fwd_data_b;

  register_writeback_unit_if in_if ();

  register_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .hold       (hold),
    .flush      (flush),
    .r          (r),
    .en         (en),
    .busy       (busy),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  wb_entry_t sb [$];
  wb_entry_t mon_e;
  int        st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (en !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_write_en", 32'(en), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_en",   32'(en), 32'(16'h0001 << mon_e.dst));
        check("wr_data", 32'(r),  32'(mon_e.data));
      end
    end else begin
      check("idle_r", 32'(r), 32'h0);
    end
  end

  // Present one result and wait (bounded) for its transfer edge. Returns at
  // transfer edge + 1, with the expectation pushed when a write is due.
  task automatic push(input reg_idx_t dst, input data_t data, input logic wr,
                      input bit expect_wr, output int stalls);
    bit done;
    stalls         = 0;
    done           = 1'b0;
    in_if.in_valid = 1'b1;
    in_if.in_wr    = wr;
    in_if.in_dst   = dst;
    in_if.in_data  = data;
    while (!done) begin
      @(negedge clk);
      if (in_if.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        if (expect_wr) sb.push_back('{dst: dst, data: data});
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 50) begin
          check("push_timeout", 32'(stalls), 32'h0);
          done = 1'b1;
        end
      end
    end
    in_if.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_wr    = 1'b0;
    in_if.in_dst   = '0;
    in_if.in_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_if.in_ready), 32'h0);
    check("rst_en",        32'(en),             32'h0);
    check("rst_busy",      32'(busy),           32'h0);
    check("rst_fwd_hit_a", 32'(fwd_hit_a),      32'h0);
    check("rst_fwd_hit_b", 32'(fwd_hit_b),      32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_if.in_ready), 32'h1);

    // Single write, minimum latency
    @(posedge clk); #1;
    push(4'd3, 16'hBEEF, 1'b1, 1'b1, st);
    @(negedge clk);
    check("single_en",   32'(en),   32'h0008);
    check("single_r",    32'(r),    32'hBEEF);
    check("single_busy", 32'(busy), 32'h0008);
    @(negedge clk);
    check("single_en_after",   32'(en),   32'h0);
    check("single_busy_after", 32'(busy), 32'h0);

    // Fill under hold, then drain in order
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(reg_idx_t'(i), 16'hA000 + 16'(i), 1'b1, 1'b1, st);
    @(negedge clk);
    check("full_ready", 32'(in_if.in_ready), 32'h0);
    check("full_busy",  32'(busy),           32'h001E);
    check("full_en",    32'(en),             32'h0);
    @(posedge clk); #1 hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("drain_en", 32'(en), 32'(16'h0001 << i));
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'h0);

    // Non-writing result is consumed silently
    @(posedge clk); #1;
    push(4'd5, 16'h5555, 1'b0, 1'b0, st);
    check("nowr_stall", 32'(st), 32'h0);
    @(negedge clk);
    check("nowr_ready", 32'(in_if.in_ready), 32'h1);
    check("nowr_busy",  32'(busy),           32'h0);
    check("nowr_en",    32'(en),             32'h0);

    // Same-register entries: forwarding picks the youngest, both written
    @(posedge clk); #1;
    hold      = 1'b1;
    fwd_sel_a = 4'd7;
    fwd_sel_b = 4'd3;
    push(4'd7, 16'h1111, 1'b1, 1'b1, st);
    push(4'd7, 16'h2222, 1'b1, 1'b1, st);
    @(negedge clk);
    check("fwd_hit_a",  32'(fwd_hit_a),  32'(FWD));
    check("fwd_data_a", 32'(fwd_data_a), FWD ? 32'h2222 : 32'h0);
    check("fwd_hit_b",  32'(fwd_hit_b),  32'h0);
    check("fwd_data_b", 32'(fwd_data_b), 32'h0);
    check("fwd_busy",   32'(busy),       32'h0080);
    @(posedge clk); #1 hold = 1'b0;
    repeat (3) @(negedge clk);
    check("fwd_busy_after", 32'(busy),      32'h0);
    check("fwd_hit_after",  32'(fwd_hit_a), 32'h0);

    // Flush with three queued entries; flush also beats a released hold
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 9; i <= 11; i++) push(reg_idx_t'(i), 16'hF000 + 16'(i), 1'b1, 1'b0, st);
    @(negedge clk);
    check("pre_flush_busy", 32'(busy), 32'h0E00);
    @(posedge clk); #1;
    flush = 1'b1;
    hold  = 1'b0;
    @(negedge clk);
    check("flush_en",    32'(en),             32'h0);
    check("flush_ready", 32'(in_if.in_ready), 32'h0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("post_flush_busy",  32'(busy),           32'h0);
    check("post_flush_ready", 32'(in_if.in_ready), 32'h1);
    check("post_flush_en",    32'(en),             32'h0);

    // Same scenario with reset
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 12; i <= 14; i++) push(reg_idx_t'(i), 16'hC000 + 16'(i), 1'b1, 1'b0, st);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h7000);
    @(posedge clk); #1;
    rst  = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    check("midrst_en",    32'(en),             32'h0);
    check("midrst_ready", 32'(in_if.in_ready), 32'h0);
    check("midrst_busy",  32'(busy),           32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy",  32'(busy),           32'h0);
    check("post_rst_ready2",32'(in_if.in_ready), 32'h1);
    check("post_rst_en",    32'(en),             32'h0);

    // Back-to-back stream across all registers, wrapping the pointers
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      push(reg_idx_t'(i), 16'(i) * 16'h0101, 1'b1, 1'b1, st);
      check("stream_stall", 32'(st), 32'h0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    check("final_busy",       32'(busy),      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_writeback_unit.md
REGISTER_WRITEBACK_UNIT -- requirements
Module: register_writeback_unit

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued writeback entries; power of two, 2..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer has a result this cycle.
REQ-005 in_ready  output  1  unit can accept a result this cycle.
REQ-006 in_wr  input  1  result targets a register; 0 for st and for jmp without fn.
REQ-007 in_dst  input  4  destination register index.
REQ-008 in_data  input  16  result value.
REQ-009 hold  input  1  register-file write port is taken by another writer this cycle.
REQ-010 flush  input  1  discard all queued results.
REQ-011 r  output  16  write data to the register file.
REQ-012 en  output  16  one-hot register-file write enable, bit k selects register k.
REQ-013 busy  output  16  bit k set while any queued entry targets register k.
REQ-014 fwd_sel_a, fwd_sel_b  input  4 each  register indices to look up for forwarding.
REQ-015 fwd_hit_a, fwd_hit_b  output  1 each  lookup matched a queued entry.
REQ-016 fwd_data_a, fwd_data_b  output  16 each  forwarded value.

Function
REQ-017 Queue SHALL be FIFO of DEPTH entries {dst[3:0], data[15:0]} with head/tail pointers and an occupancy count 0..DEPTH.
REQ-018 in_ready SHALL be 1 iff count < DEPTH, rst = 0 and flush = 0; pop on a full queue does not raise in_ready that cycle.
REQ-019 Handshake: transfer occurs iff in_valid & in_ready at a rising edge; in_dst/in_data SHALL be held stable by the producer until transfer.
REQ-020 Transfer with in_wr = 1 SHALL enqueue at tail; transfer with in_wr = 0 SHALL be consumed and discarded, no queue change.
REQ-021 Drain: when count > 0 and hold = 0 and flush = 0, en SHALL be one-hot of head dst, r SHALL equal head data, and head SHALL pop at the edge; otherwise en = 0 and r = 0.
REQ-022 r and en SHALL be combinational from head state only (no input-to-output path) so the register file captures on the same edge as the pop.
REQ-023 Latency: a result transferred at edge N SHALL drive en during cycle N+1 at the earliest (empty queue, hold = 0) and be visible in the register file after edge N+1.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 busy[k] SHALL be the OR over valid entries of (dst == k), combinational from queue state.
REQ-027 flush SHALL, at the edge, set count and pointers to 0, perform no write (en = 0) and accept no input that cycle; flush overrides hold.
REQ-028 Two consecutive entries to the same register SHALL both be written, in order.

Reset
REQ-029 While rst = 1: en = 0, r = 0, busy = 0, in_ready = 0, fwd_hit_a/b = 0; at the edge count, head and tail SHALL become 0.
REQ-030 Reset mid-operation SHALL discard all queued entries without writing them.
REQ-031 Storage data contents need not be reset.

Configuration
REQ-032 Macro WB_FORWARD_EN: when defined, fwd_hit_x = 1 iff a valid entry has dst == fwd_sel_x, and fwd_data_x = data of the youngest such entry (nearest tail).
REQ-033 Without WB_FORWARD_EN, fwd ports SHALL remain present and fwd_hit_a/b = 0, fwd_data_a/b = 0; all other behaviour identical.

Structure
REQ-034 Shared package lite16_wb_pkg SHALL hold REG_IDX_W = 4, DATA_W = 16, NUM_REGS = 16 and the entry field layout.
REQ-035 One sub-module wb_fifo SHALL hold storage, pointers and count; scoreboard, forwarding and one-hot decode stay in register_writeback_unit.

Verification
REQ-036 Empty queue, push {dst 3, 0xBEEF}, hold = 0 -> next cycle en = 0x0008, r = 0xBEEF; following cycle en = 0, busy = 0.
REQ-037 hold = 1, push dst 1, 2, 3, 4 (DEPTH 4) -> in_ready = 0, busy = 0x001E; release hold -> en = 0x0002, 0x0004, 0x0008, 0x0010 on four consecutive cycles.
REQ-038 Push dst 5 with in_wr = 0 -> accepted, in_ready stays 1, en never asserts, busy = 0.
REQ-039 hold = 1, queue {dst 7, 0x1111}, {dst 7, 0x2222}, fwd_sel_a = 7 -> with WB_FORWARD_EN fwd_hit_a = 1, fwd_data_a = 0x2222; without it fwd_hit_a = 0.
REQ-040 Three entries queued, assert flush one cycle -> no en pulse, busy = 0, in_ready = 1 next cycle; same with rst instead of flush.
REQ-041 Continuous push every cycle, hold = 0, dst 0..15 with data = dst * 0x0101 -> one write per cycle in order, in_ready never drops, wrap-around exercised.
